// File: rtl/freq_pkg.sv
// Shared definitions for the frequency meter: gate FSM states, BCD limits and
// the default gate window length also used by the display path.
package freq_pkg;

  typedef enum logic [1:0] {
    GATE  = 2'd0,
    SAVE  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX             = 4'd9;
  localparam int         DIGITS              = 4;
  localparam int         GATE_CYCLES_DEFAULT = 50_000_000;

  // Any code above 9 also wraps to 0, so a disturbed digit recovers to BCD.
  function automatic logic [3:0] bcd_next(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD edge counter: synchronous clear, increment with
// carry-out when rolling from 9 to 0.
module bcd_digit
  import freq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc & (q == BCD_MAX);

  // Decade register; clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= bcd_next(q);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/freq_gate_counter.sv
// Frequency meter front end: counts synchronized rising edges of sig_in over a
// gate window, strobes save low once per window, then clears and reopens.
module freq_gate_counter
  import freq_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
  parameter int GW          = 26
) (
  input  logic       c_clk,
  input  logic       rst,
  input  logic       sig_in,
  output logic [3:0] th_d,
  output logic [3:0] hundred_d,
  output logic [3:0] ten_d,
  output logic [3:0] one_d,
  output logic       save,
  output logic       over
);

  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0] GATE_ONE  = GW'(1);

  state_t            state;
  logic [GW-1:0]     gate_cnt;
  logic              ovf_flag;
  logic              s1, s2, s3;
  logic              rise, counting, all_max, ovf_event, clr;
  logic [DIGITS-1:0] inc, carry;
  logic [3:0]        dig [DIGITS];

  // Two-stage synchronizer plus a delay stage for rising-edge detection.
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign counting = (state == GATE) & rise;
  assign clr      = (state == CLEAR);
  assign all_max  = (dig[0] == BCD_MAX) & (dig[1] == BCD_MAX) &
                    (dig[2] == BCD_MAX) & (dig[3] == BCD_MAX);

  // Saturation: at 9999 the edge is swallowed here and only flags overflow.
  assign inc[0]          = counting & ~all_max;
  assign inc[DIGITS-1:1] = carry[DIGITS-2:0];
  assign ovf_event       = (counting & all_max) | carry[DIGITS-1];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk  (c_clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (inc[i]),
      .q    (dig[i]),
      .carry(carry[i])
    );
  end

  assign one_d     = dig[0];
  assign ten_d     = dig[1];
  assign hundred_d = dig[2];
  assign th_d      = dig[3];

  // Gate sequencer with registered save strobe and overflow indication.
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      state    <= GATE;
      gate_cnt <= {GW{1'b0}};
      save     <= 1'b1;
      over     <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        GATE: begin
          if (ovf_event) begin
            ovf_flag <= 1'b1;
          end else begin
            ovf_flag <= ovf_flag;
          end
          if (gate_cnt == GATE_LAST) begin
            state    <= SAVE;
            gate_cnt <= {GW{1'b0}};
            save     <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GATE_ONE;
            save     <= 1'b1;
          end
        end
        SAVE: begin
          save  <= 1'b1;
          over  <= ovf_flag;
          state <= CLEAR;
        end
        CLEAR: begin
          save     <= 1'b1;
          ovf_flag <= 1'b0;
          state    <= GATE;
        end
        default: begin
          state    <= GATE;
          gate_cnt <= {GW{1'b0}};
          save     <= 1'b1;
          ovf_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Randomized self-checking bench for freq_gate_counter; expected values come
// from window arithmetic over the recorded sig_in rise times.
module tb_freq_gate_counter;

  localparam int G  = 100;
  localparam int P  = G + 2;
  localparam int GB = 30000;
  localparam int PB = GB + 2;

  logic       c_clk = 1'b0;
  logic       rst = 1'b1, sig_in = 1'b0, rst_b = 1'b1, sig_in_b = 1'b0;
  logic [3:0] th_d, hundred_d, ten_d, one_d;
  logic [3:0] th_b, hundred_b, ten_b, one_b;
  logic       save, over, save_b, over_b;

  int cyc = 0, cyc_b = 0;
  int qa[$];
  int qb[$];
  int vectors = 0, miscompares = 0;

  always #5 c_clk = ~c_clk;

  freq_gate_counter #(.GATE_CYCLES(G), .GW(26)) dut (
    .c_clk(c_clk), .rst(rst), .sig_in(sig_in),
    .th_d(th_d), .hundred_d(hundred_d), .ten_d(ten_d), .one_d(one_d),
    .save(save), .over(over)
  );

  freq_gate_counter #(.GATE_CYCLES(GB), .GW(26)) dut_b (
    .c_clk(c_clk), .rst(rst_b), .sig_in(sig_in_b),
    .th_d(th_b), .hundred_d(hundred_b), .ten_d(ten_b), .one_d(one_b),
    .save(save_b), .over(over_b)
  );

  // Cycle index since reset release: interval k lies between posedge k and k+1.
  always @(posedge c_clk) begin
    if (rst) cyc <= 0; else cyc <= cyc + 1;
    if (rst_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;
  end

  // A rise driven in interval r reaches the counter on posedge r+3, so it is
  // counted iff interval r+2 is a gate interval of its window.
  function automatic int win_count(input int q[$], input int k, input int g);
    int p, w, n, t;
    p = g + 2; w = k / p; n = 0;
    foreach (q[i]) begin
      t = q[i] + 2;
      if (t / p == w && t % p < g && t < k) n++;
    end
    return n;
  endfunction

  function automatic logic model_over(input int q[$], input int k, input int g);
    int p, j, n, t;
    p = g + 2;
    if (k <= g) return 1'b0;
    j = (k - g - 1) / p;
    n = 0;
    foreach (q[i]) begin
      t = q[i] + 2;
      if (t / p == j && t % p < g) n++;
    end
    return (n > 9999);
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    int m;
    m = (n > 9999) ? 9999 : n;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic drive_a(input logic v);
    if (v === 1'b1 && sig_in !== 1'b1) qa.push_back(cyc);
    sig_in = v;
  endtask

  task automatic drive_b(input logic v);
    if (v === 1'b1 && sig_in_b !== 1'b1) qb.push_back(cyc_b);
    sig_in_b = v;
  endtask

  task automatic wait_phase_a(input int ph);
    for (int n = 0; n < P + 2; n++) begin
      if (cyc % P == ph) break;
      @(negedge c_clk);
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    logic [15:0] exp_d;
    int saves;
    rst = 1'b1; sig_in = 1'b0; rst_b = 1'b1; sig_in_b = 1'b0;
    repeat (3) begin
      @(negedge c_clk);
      got = {th_d, hundred_d, ten_d, one_d};
      vectors++;
      if (got !== 16'h0000 || save !== 1'b1 || over !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold got digits=%h save=%b over=%b want 0000/1/0", got, save, over);
      end
    end
    rst = 1'b0;
    qa.delete();
    saves = 0;
    for (int i = 0; i < 2 * P + 3; i++) begin
      @(negedge c_clk);
      exp_d = to_bcd(win_count(qa, cyc, G));
      got = {th_d, hundred_d, ten_d, one_d};
      vectors++;
      if (got !== exp_d) begin miscompares++; $display("FAIL reset_digits k=%0d got %h want %h", cyc, got, exp_d); end
      vectors++;
      if (save !== ((cyc % P == G) ? 1'b0 : 1'b1)) begin miscompares++; $display("FAIL reset_save k=%0d got %b", cyc, save); end
      vectors++;
      if (over !== 1'b0) begin miscompares++; $display("FAIL reset_over k=%0d got %b want 0", cyc, over); end
      if (save === 1'b0) saves++;
    end
    vectors++;
    if (saves != 2) begin miscompares++; $display("FAIL reset_save_count got %0d want 2", saves); end
  endtask

  task automatic test_period10();
    logic [15:0] got;
    logic [15:0] exp_d;
    int off, saves, val;
    off = int'($urandom_range(0, 9));
    wait_phase_a(P - 1);
    saves = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge c_clk);
      exp_d = to_bcd(win_count(qa, cyc, G));
      got = {th_d, hundred_d, ten_d, one_d};
      vectors++;
      if (got !== exp_d) begin miscompares++; $display("FAIL p10_digits k=%0d got %h want %h", cyc, got, exp_d); end
      vectors++;
      if (save !== ((cyc % P == G) ? 1'b0 : 1'b1)) begin miscompares++; $display("FAIL p10_save k=%0d got %b", cyc, save); end
      vectors++;
      if (over !== model_over(qa, cyc, G)) begin miscompares++; $display("FAIL p10_over k=%0d got %b", cyc, over); end
      if (save === 1'b0) begin
        saves++;
        val = th_d * 1000 + hundred_d * 100 + ten_d * 10 + one_d;
        vectors++;
        if (val < 9 || val > 11) begin miscompares++; $display("FAIL p10_latched got %0d want 10+/-1", val); end
      end
      drive_a(((i + off) % 10) < 5);
    end
    drive_a(1'b0);
    vectors++;
    if (saves != 1) begin miscompares++; $display("FAIL p10_save_count got %0d want 1", saves); end
  endtask

  task automatic test_carry();
    logic [15:0] got;
    logic [15:0] exp_d;
    wait_phase_a(P - 1);
    for (int i = 0; i <= P; i++) begin
      @(negedge c_clk);
      exp_d = to_bcd(win_count(qa, cyc, G));
      got = {th_d, hundred_d, ten_d, one_d};
      vectors++;
      if (got !== exp_d) begin miscompares++; $display("FAIL carry_digits k=%0d got %h want %h", cyc, got, exp_d); end
      vectors++;
      if (save !== ((cyc % P == G) ? 1'b0 : 1'b1)) begin miscompares++; $display("FAIL carry_save k=%0d got %b", cyc, save); end
      if (i == 38) begin
        vectors++;
        if (got !== 16'h0009) begin miscompares++; $display("FAIL carry_pre got %h want 0009", got); end
      end
      if (i == 39) begin
        vectors++;
        if (got !== 16'h0010) begin miscompares++; $display("FAIL carry_post got %h want 0010", got); end
      end
      if (i == G) begin
        vectors++;
        if (got !== 16'h0017 || save !== 1'b0) begin miscompares++; $display("FAIL carry_latched got %h save=%b want 0017/0", got, save); end
      end
      if (i == P) begin
        vectors++;
        if (got !== 16'h0000) begin miscompares++; $display("FAIL carry_cleared got %h want 0000", got); end
      end
      drive_a((i < 68) && (i % 4 < 2));
    end
    drive_a(1'b0);
  endtask

  task automatic test_boundary();
    logic [15:0] got;
    logic [15:0] exp_d;
    wait_phase_a(P - 1);
    for (int i = 0; i <= P + G; i++) begin
      @(negedge c_clk);
      exp_d = to_bcd(win_count(qa, cyc, G));
      got = {th_d, hundred_d, ten_d, one_d};
      vectors++;
      if (got !== exp_d) begin miscompares++; $display("FAIL bound_digits k=%0d got %h want %h", cyc, got, exp_d); end
      if (i == G || i == P + G) begin
        vectors++;
        if (got !== ((i == G) ? 16'h0001 : 16'h0000) || save !== 1'b0) begin
          miscompares++; $display("FAIL bound_latched i=%0d got %h save=%b", i, got, save);
        end
      end
      drive_a(i == G - 3 || i == G - 1 || i == P + G - 2);
    end
    drive_a(1'b0);
  endtask

  task automatic test_random();
    logic [15:0] got;
    logic [15:0] exp_d;
    logic v;
    int run;
    v = 1'b0; run = 0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge c_clk);
      exp_d = to_bcd(win_count(qa, cyc, G));
      got = {th_d, hundred_d, ten_d, one_d};
      vectors++;
      if (got !== exp_d) begin miscompares++; $display("FAIL rand_digits k=%0d got %h want %h", cyc, got, exp_d); end
      vectors++;
      if (save !== ((cyc % P == G) ? 1'b0 : 1'b1)) begin miscompares++; $display("FAIL rand_save k=%0d got %b", cyc, save); end
      vectors++;
      if (over !== model_over(qa, cyc, G)) begin miscompares++; $display("FAIL rand_over k=%0d got %b", cyc, over); end
      if (run == 0) begin
        v = ~v;
        run = int'($urandom_range(1, 5));
      end
      run--;
      drive_a(v);
    end
    drive_a(1'b0);
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    logic [15:0] exp_d;
    int first_save;
    wait_phase_a(30);
    for (int i = 0; i < 20; i++) begin
      @(negedge c_clk);
      drive_a(i % 4 < 2);
    end
    drive_a(1'b0);
    #2 rst = 1'b1;
    #1;
    got = {th_d, hundred_d, ten_d, one_d};
    vectors++;
    if (got !== 16'h0000 || save !== 1'b1 || over !== 1'b0) begin
      miscompares++; $display("FAIL rmid_async got digits=%h save=%b over=%b want 0000/1/0", got, save, over);
    end
    repeat (3) begin
      @(negedge c_clk);
      vectors++;
      if (save !== 1'b1 || {th_d, hundred_d, ten_d, one_d} !== 16'h0000) begin
        miscompares++; $display("FAIL rmid_hold got save=%b digits=%h want 1/0000", save, {th_d, hundred_d, ten_d, one_d});
      end
    end
    rst = 1'b0;
    qa.delete();
    first_save = -1;
    for (int i = 0; i < G + 3; i++) begin
      @(negedge c_clk);
      exp_d = to_bcd(win_count(qa, cyc, G));
      got = {th_d, hundred_d, ten_d, one_d};
      vectors++;
      if (got !== exp_d) begin miscompares++; $display("FAIL rmid_digits k=%0d got %h want %h", cyc, got, exp_d); end
      if (save === 1'b0 && first_save < 0) first_save = cyc;
      drive_a((i > 5) && (i < 40) && (i % 6 < 3));
    end
    drive_a(1'b0);
    vectors++;
    if (first_save != G) begin miscompares++; $display("FAIL rmid_first_save got %0d want %0d", first_save, G); end
  endtask

  task automatic test_saturate();
    logic [15:0] got;
    logic [15:0] exp_d;
    sig_in_b = 1'b0;
    rst_b = 1'b0;
    qb.delete();
    for (int k = 1; k <= PB + GB + 1; k++) begin
      @(negedge c_clk);
      got = {th_b, hundred_b, ten_b, one_b};
      vectors++;
      if (save_b !== ((cyc_b % PB == GB) ? 1'b0 : 1'b1)) begin miscompares++; $display("FAIL sat_save k=%0d got %b", cyc_b, save_b); end
      if (k == GB || k == PB + GB) begin
        exp_d = to_bcd(win_count(qb, cyc_b, GB));
        vectors++;
        if (got !== exp_d || got !== ((k == GB) ? 16'h9999 : 16'h0005)) begin
          miscompares++; $display("FAIL sat_latched k=%0d got %h want %h", cyc_b, got, exp_d);
        end
        vectors++;
        if (over_b !== model_over(qb, cyc_b, GB)) begin miscompares++; $display("FAIL sat_over_hold k=%0d got %b", cyc_b, over_b); end
      end
      if (k == GB + 1 || k == PB + GB + 1) begin
        vectors++;
        if (over_b !== ((k == GB + 1) ? 1'b1 : 1'b0) || over_b !== model_over(qb, cyc_b, GB)) begin
          miscompares++; $display("FAIL sat_over k=%0d got %b", cyc_b, over_b);
        end
      end
      if (k < GB) drive_b(k % 2 == 1);
      else drive_b((k >= PB + 10) && (k <= PB + 50) && ((k - PB) % 10 == 0));
    end
    drive_b(1'b0);
  endtask

  initial begin
    test_reset();
    test_period10();
    test_carry();
    test_boundary();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
